// File: rtl/register_scoreboard.sv
// Per-register pending-write scoreboard between ID and WB, with ID stall generation.
// Optional stall-cycle performance counter enabled by SCOREBOARD_PERF_EN.
module register_scoreboard #(
    parameter int unsigned NUM_REGS     = 16,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        issue_valid,
    input  logic                        issue_we,
    input  logic [$clog2(NUM_REGS)-1:0] issue_rd,
    input  logic                        retire_valid,
    input  logic                        retire_we,
    input  logic [$clog2(NUM_REGS)-1:0] retire_rd,
    input  logic                        flush,
    input  logic [$clog2(NUM_REGS)-1:0] rs1,
    input  logic [$clog2(NUM_REGS)-1:0] rs2,
    input  logic                        rs1_used,
    input  logic                        rs2_used,
    input  logic                        rs1_data_forwarded,
    input  logic                        rs2_data_forwarded,
    output logic                        stall_ID,
    output logic [NUM_REGS-1:0]         pending_mask,
    output logic                        underflow_err
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [31:0]                 stall_cycles
`endif
);

    localparam int unsigned CntW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_INFLIGHT);

    logic [CntW-1:0]     count_q [NUM_REGS];
    logic [CntW-1:0]     count_d [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;

    logic issue_hit;
    logic issue_acc;
    logic retire_acc;
    logic haz1;
    logic haz2;
    logic full;
    logic underflow_q;
    logic underflow_d;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            pending[i] = (count_q[i] != '0);
        end
    end

    assign pending_mask = pending;

    // Stall depends only on registered counts and issue/source inputs, never on retire.
    assign issue_hit = issue_valid & issue_we & (issue_rd != '0);
    assign full      = issue_hit & (count_q[issue_rd] == MaxCnt);
    assign haz1      = rs1_used & (rs1 != '0) & pending[rs1] & ~rs1_data_forwarded;
    assign haz2      = rs2_used & (rs2 != '0) & pending[rs2] & ~rs2_data_forwarded;
    assign stall_ID  = haz1 | haz2 | full;

    assign issue_acc  = issue_hit & ~stall_ID & ~flush;
    assign retire_acc = retire_valid & retire_we & (retire_rd != '0) & ~flush;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issue_acc) begin
            inc_vec[issue_rd] = 1'b1;
        end
        if (retire_acc) begin
            dec_vec[retire_rd] = 1'b1;
        end
    end

    // Issue and retire to the same register in one cycle cancel out.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            count_d[i] = count_q[i];
            if (flush) begin
                count_d[i] = '0;
            end else if (inc_vec[i] && !dec_vec[i] && (count_q[i] != MaxCnt)) begin
                count_d[i] = count_q[i] + CntW'(1);
            end else if (dec_vec[i] && !inc_vec[i] && (count_q[i] != '0)) begin
                count_d[i] = count_q[i] - CntW'(1);
            end
        end
        count_d[0] = '0;
    end

    assign underflow_d = underflow_q | (retire_acc & (count_q[retire_rd] == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                count_q[i] <= '0;
            end
            underflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                count_q[i] <= count_d[i];
            end
            underflow_q <= underflow_d;
        end
    end

    assign underflow_err = underflow_q;

`ifdef SCOREBOARD_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;

    // Flush cycles are not charged as stalls; the counter wraps naturally.
    assign stall_cycles_d = stall_cycles_q + {31'b0, stall_ID & ~flush};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed scoreboard bench for register_scoreboard; expectations queued by stimulus,
// compared by a negedge monitor.
module tb_register_scoreboard;

    localparam int KStall = 0;
    localparam int KMask  = 1;
    localparam int KUnder = 2;
    localparam int KPerf  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic        issue_we = 1'b0;
    logic [3:0]  issue_rd = '0;
    logic        retire_valid = 1'b0;
    logic        retire_we = 1'b0;
    logic [3:0]  retire_rd = '0;
    logic        flush = 1'b0;
    logic [3:0]  rs1 = '0;
    logic [3:0]  rs2 = '0;
    logic        rs1_used = 1'b0;
    logic        rs2_used = 1'b0;
    logic        rs1_data_forwarded = 1'b0;
    logic        rs2_data_forwarded = 1'b0;
    logic        stall_ID;
    logic [15:0] pending_mask;
    logic        underflow_err;
`ifdef SCOREBOARD_PERF_EN
    logic [31:0] stall_cycles;
`endif

    register_scoreboard #(
        .NUM_REGS    (16),
        .MAX_INFLIGHT(4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .issue_valid       (issue_valid),
        .issue_we          (issue_we),
        .issue_rd          (issue_rd),
        .retire_valid      (retire_valid),
        .retire_we         (retire_we),
        .retire_rd         (retire_rd),
        .flush             (flush),
        .rs1               (rs1),
        .rs2               (rs2),
        .rs1_used          (rs1_used),
        .rs2_used          (rs2_used),
        .rs1_data_forwarded(rs1_data_forwarded),
        .rs2_data_forwarded(rs2_data_forwarded),
        .stall_ID          (stall_ID),
        .pending_mask      (pending_mask),
        .underflow_err     (underflow_err)
`ifdef SCOREBOARD_PERF_EN
        ,
        .stall_cycles      (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    chk_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic expect_val(input string name, input int kind, input logic [31:0] v);
        chk_t c;
        c.name = name;
        c.kind = kind;
        c.exp  = v;
        exp_q.push_back(c);
    endtask

    // Monitor: every expectation queued in a cycle is checked at that cycle's falling edge.
    always @(negedge clk) begin : monitor
        chk_t        c;
        logic [31:0] act;
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            case (c.kind)
                KStall:  act = {31'b0, stall_ID};
                KMask:   act = {16'b0, pending_mask};
                KUnder:  act = {31'b0, underflow_err};
`ifdef SCOREBOARD_PERF_EN
                KPerf:   act = stall_cycles;
`endif
                default: act = 32'hdead_beef;
            endcase
            n_checks++;
            if (act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", c.name, act, c.exp,
                         $time);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        issue_valid        = 1'b0;
        issue_we           = 1'b0;
        issue_rd           = '0;
        retire_valid       = 1'b0;
        retire_we          = 1'b0;
        retire_rd          = '0;
        flush              = 1'b0;
        rs1                = '0;
        rs2                = '0;
        rs1_used           = 1'b0;
        rs2_used           = 1'b0;
        rs1_data_forwarded = 1'b0;
        rs2_data_forwarded = 1'b0;
    endtask

    task automatic do_issue(input logic [3:0] rd);
        issue_valid = 1'b1;
        issue_we    = 1'b1;
        issue_rd    = rd;
    endtask

    task automatic do_retire(input logic [3:0] rd);
        retire_valid = 1'b1;
        retire_we    = 1'b1;
        retire_rd    = rd;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // Reset state
        cyc();
        expect_val("reset_stall", KStall, 32'd0);
        expect_val("reset_mask", KMask, 32'd0);
        expect_val("reset_underflow", KUnder, 32'd0);
`ifdef SCOREBOARD_PERF_EN
        expect_val("reset_perf", KPerf, 32'd0);
`endif
        cyc();
        rst = 1'b0;

        // Load-use on x5
        cyc(); do_issue(4'd5);
        expect_val("lu_issue_nostall", KStall, 32'd0);
        expect_val("lu_mask_before", KMask, 32'd0);
        cyc(); rs1 = 4'd5; rs1_used = 1'b1;
        expect_val("lu_mask_pending", KMask, 32'h0020);
        expect_val("lu_stall", KStall, 32'd1);
        cyc(); rs1 = 4'd5; rs1_used = 1'b1; rs1_data_forwarded = 1'b1;
        expect_val("lu_fwd_nostall", KStall, 32'd0);
        cyc(); do_retire(4'd5);
        expect_val("lu_mask_retire_cycle", KMask, 32'h0020);
        cyc();
        expect_val("lu_mask_cleared", KMask, 32'd0);

        // Saturation on x3
        for (int k = 0; k < 4; k++) begin
            cyc(); do_issue(4'd3);
            expect_val("sat_issue_nostall", KStall, 32'd0);
        end
        cyc(); do_issue(4'd3);
        expect_val("sat_full_stall", KStall, 32'd1);
        expect_val("sat_mask", KMask, 32'h0008);
        cyc(); do_issue(4'd3); do_retire(4'd3);
        expect_val("sat_full_with_retire", KStall, 32'd1);
        for (int k = 0; k < 3; k++) begin
            cyc(); do_retire(4'd3);
            expect_val("sat_drain_pending", KMask, 32'h0008);
        end
        cyc();
        expect_val("sat_drained", KMask, 32'd0);

        // Simultaneous issue/retire on x7
        cyc(); do_issue(4'd7);
        expect_val("sim_issue", KStall, 32'd0);
        cyc(); do_issue(4'd7); do_retire(4'd7);
        expect_val("sim_mask_before", KMask, 32'h0080);
        cyc(); rs1 = 4'd7; rs1_used = 1'b1;
        expect_val("sim_mask_after", KMask, 32'h0080);
        expect_val("sim_stall", KStall, 32'd1);
        cyc(); do_retire(4'd7);
        expect_val("sim_mask_last", KMask, 32'h0080);
        cyc();
        expect_val("sim_mask_cleared", KMask, 32'd0);
        expect_val("sim_no_underflow", KUnder, 32'd0);

        // x0 never tracked
        cyc(); do_issue(4'd0);
        expect_val("x0_issue_nostall", KStall, 32'd0);
        cyc(); rs2 = 4'd0; rs2_used = 1'b1;
        expect_val("x0_mask", KMask, 32'd0);
        expect_val("x0_rs2_nostall", KStall, 32'd0);

        // Flush and underflow
        cyc(); do_issue(4'd2);
        cyc(); do_issue(4'd9);
        cyc();
        expect_val("fl_mask_loaded", KMask, 32'h0204);
        cyc(); flush = 1'b1; do_issue(4'd4);
        expect_val("fl_mask_flush_cycle", KMask, 32'h0204);
        expect_val("fl_stall", KStall, 32'd0);
        cyc();
        expect_val("fl_mask_cleared", KMask, 32'd0);
        cyc(); rs1 = 4'd4; rs1_used = 1'b1;
        expect_val("fl_x4_dropped", KStall, 32'd0);
        cyc(); do_retire(4'd2);
        expect_val("uf_before", KUnder, 32'd0);
        cyc();
        expect_val("uf_set", KUnder, 32'd1);
        expect_val("uf_mask_zero", KMask, 32'd0);
        cyc(); flush = 1'b1;
        expect_val("uf_sticky_flush_cycle", KUnder, 32'd1);
        cyc();
        expect_val("uf_sticky_after_flush", KUnder, 32'd1);

        // Asynchronous mid-cycle reset with counts loaded
        cyc(); do_issue(4'd11);
        cyc(); do_issue(4'd12);
        cyc(); rs1 = 4'd11; rs1_used = 1'b1;
        expect_val("ar_mask_loaded", KMask, 32'h1800);
        expect_val("ar_stall_loaded", KStall, 32'd1);
        cyc(); rs1 = 4'd11; rs1_used = 1'b1;
        #2 rst = 1'b1;
        expect_val("ar_mask_cleared", KMask, 32'd0);
        expect_val("ar_stall_cleared", KStall, 32'd0);
        expect_val("ar_underflow_cleared", KUnder, 32'd0);
        cyc();
        rst = 1'b0;
        expect_val("ar_mask_released", KMask, 32'd0);
`ifdef SCOREBOARD_PERF_EN
        expect_val("perf_zero_after_reset", KPerf, 32'd0);
`endif

        // Hazard held six cycles, last one flushed
        cyc(); do_issue(4'd6);
        expect_val("perf_issue", KStall, 32'd0);
        for (int k = 0; k < 6; k++) begin
            cyc(); rs1 = 4'd6; rs1_used = 1'b1;
            if (k == 5) flush = 1'b1;
            expect_val("perf_hazard_stall", KStall, 32'd1);
        end
        cyc();
        expect_val("perf_mask_flushed", KMask, 32'd0);
`ifdef SCOREBOARD_PERF_EN
        expect_val("perf_stall_cycles", KPerf, 32'd5);
`endif

        cyc();
        cyc();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL queue_drain: %0d expectations unchecked, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
